// File: rtl/s_rx_word_fifo_if.sv
// s_rx_word_fifo_if: valid/ready word stream from the receive FIFO to application logic.
interface s_rx_word_fifo_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/s_rx_word_fifo.sv
// s_rx_word_fifo: captures SPI slave receive words on a status rising edge into a FWFT FIFO.
// Optional S_RXBUF_SWAP_EN: each stored word has its 32-bit halves exchanged (DATA_W=64 only).
module s_rx_word_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned OVF_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                status,
    input  logic [DATA_W-1:0]   in_word,
    s_rx_word_fifo_if.master    out_if,
    output logic [ADDR_W:0]     level,
    output logic                full,
    output logic                ovf_flag,
    output logic [OVF_W-1:0]    ovf_cnt,
    input  logic                clr_ovf
);
    localparam int unsigned      LVL_W    = ADDR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [OVF_W-1:0] OVF_MAX  = '1;

    logic              status_d;
    logic              armed;
    logic              valid_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic              ovf_flag_nxt;
    logic [OVF_W-1:0]  ovf_cnt_nxt;
    logic              cap_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic [DATA_W-1:0] wr_word_c;
    logic [DATA_W-1:0] mem [DEPTH];

`ifdef S_RXBUF_SWAP_EN
    if (DATA_W == 64) begin : g_swap
        assign wr_word_c = {in_word[31:0], in_word[DATA_W-1:32]};
    end else begin : g_noswap
        assign wr_word_c = in_word;
    end
`else
    assign wr_word_c = in_word;
`endif

    // Strobes, pointer/level update and overflow bookkeeping
    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        level_nxt    = level;
        ovf_flag_nxt = ovf_flag;
        ovf_cnt_nxt  = ovf_cnt;

        // armed blocks a capture from a status already high when reset releases
        cap_c  = armed & status & ~status_d;
        pop_c  = valid_q & out_if.out_ready;
        push_c = cap_c & (~full | pop_c);
        drop_c = cap_c & full & ~pop_c;

        if (push_c) wr_ptr_nxt = wr_ptr + ADDR_W'(1);
        if (pop_c)  rd_ptr_nxt = rd_ptr + ADDR_W'(1);

        if (push_c && !pop_c)      level_nxt = level + LVL_W'(1);
        else if (pop_c && !push_c) level_nxt = level - LVL_W'(1);

        if (clr_ovf) begin
            ovf_flag_nxt = 1'b0;
            ovf_cnt_nxt  = '0;
        end else if (drop_c) begin
            ovf_flag_nxt = 1'b1;
            if (ovf_cnt != OVF_MAX) ovf_cnt_nxt = ovf_cnt + OVF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_d <= 1'b0;
            armed    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            valid_q  <= 1'b0;
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            status_d <= status;
            armed    <= 1'b1;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            full     <= (level_nxt == LVL_FULL);
            valid_q  <= (level_nxt != '0);
            ovf_flag <= ovf_flag_nxt;
            ovf_cnt  <= ovf_cnt_nxt;
        end
    end

    // Storage is not reset; out_valid masks stale contents
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= wr_word_c;
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = valid_q ? mem[rd_ptr] : '0;

endmodule

// File: doc/s_rx_word_fifo.md
Name: s_rx_word_fifo

Overview:
Downstream consumer of the 64-bit SPI slave core. Captures each completed 64-bit receive word, qualified by the core's status output, into a small synchronous FIFO. Presents the words to application logic over a valid/ready handshake. Counts and flags words dropped because the FIFO was full.

Parameters:
DATA_W, 64, width of one received word
DEPTH, 4, FIFO depth in words; must be a power of two and at least 2
ADDR_W, 2, log2(DEPTH); pointer width
OVF_W, 8, width of the dropped-word counter

Ports:
clk  input  1  system clock; the SPI core's status and in outputs are synchronous to it
reset  input  1  asynchronous, active-high reset (driven by the button-control block)
status  input  1  word-complete indication from the SPI core; a rising edge marks a new valid word
in_word  input  DATA_W  received word from the SPI core; stable on the cycle status rises
out_data  output  DATA_W  head-of-FIFO word; valid only while out_valid=1
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data this cycle
level  output  ADDR_W+1  number of words currently stored (0..DEPTH)
full  output  1  level==DEPTH
ovf_flag  output  1  sticky: at least one word dropped since last clear
ovf_cnt  output  OVF_W  dropped-word count; saturates at all-ones
clr_ovf  input  1  synchronous clear of ovf_flag and ovf_cnt

Behaviour:
- Reset (async assert; sync release on clk): status_d=0, wr_ptr=0, rd_ptr=0, level=0, out_valid=0, full=0, ovf_flag=0, ovf_cnt=0, out_data=0.
- Capture strobe: cap = status & ~status_d, where status_d is status registered on clk.
  - A status held high for many cycles produces exactly one capture.
  - status already high when reset releases produces no capture (status_d resets to 0 but is loaded on the first clock; capture then requires status to go low and high again). The implementation enforces this with a one-cycle arm flag set after reset.
- Push: push = cap & (~full | pop).
- Pop: pop = out_valid & out_ready.
- Storage:
  - On push, mem[wr_ptr] <= in_word (sampled in the cap cycle) and wr_ptr increments, wrapping modulo DEPTH.
  - On pop, rd_ptr increments, wrapping modulo DEPTH.
- level: +1 on push only, -1 on pop only, unchanged when both occur. The full and empty flags derive from the registered level.
- Full and pop in the same cycle: the capture is accepted, the word is not dropped, and level stays at DEPTH.
- Drop: cap & full & ~pop. The word is discarded, ovf_flag <= 1, and ovf_cnt increments, saturating at 2^OVF_W-1.
- clr_ovf coinciding with a drop: the clear wins; both are zeroed that cycle and the drop is not counted.
- out_data is first-word-fall-through:
  - always shows mem[rd_ptr] combinationally from the registered pointer;
  - a word pushed into an empty FIFO appears with out_valid=1 on the cycle after the cap cycle (latency 1).
- out_ready while out_valid=0 has no effect; pointers and level are unchanged.
- Reset mid-operation discards all stored words. Memory contents are not cleared, but out_valid=0 masks them.

Optional Feature:
Macro: S_RXBUF_SWAP_EN.
- Defined: each captured word is stored with its 32-bit halves exchanged ({in_word[31:0], in_word[63:32]}), converting the SPI core's high-half-first float pair order to the application's low-half-first order. Applies only when DATA_W=64.
- Not defined: in_word is stored unmodified. No other behaviour differs.

Test Plan:
- Single word: after reset, in_word=64'h3333333366666666, status pulses 1 cycle -> next cycle out_valid=1, out_data=64'h3333333366666666, level=1. With out_ready=1 for one cycle -> out_valid=0, level=0. With S_RXBUF_SWAP_EN -> out_data=64'h6666666633333333.
- Status held high 10 cycles with in_word=64'hA5 -> exactly one entry, level=1.
- Fill and overflow: 6 captures of words 1..6 with out_ready=0 -> level=4, full=1, ovf_flag=1, ovf_cnt=2. Four pops then yield 1,2,3,4 in order.
- Full plus simultaneous pop and capture: FIFO holds 1..4; word 5 captured while out_ready=1 -> out_data becomes 2, level stays 4, ovf_cnt unchanged, final drain order 2,3,4,5.
- Saturation and clear: 300 drops -> ovf_cnt=8'hFF. clr_ovf=1 coinciding with a drop -> ovf_cnt=0, ovf_flag=0.
- Async reset asserted mid-stream with level=3 -> immediately out_valid=0, level=0. Status held high across reset release -> no capture until status goes low and high again.
